alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage of the 8-bit ALU. Sits directly downstream of the bitwise AND/OR/XOR units and the adder.
//  Each cycle it selects one unit's result by OP, derives Z/N/C flags, and holds result+flags in a 2-entry buffer.
//  The buffer talks to the consumer (register file / test pads) over a valid/ready handshake, so the ALU can stall cleanly.
// PARAMETERS
//  WIDTH   8   datapath width; FLAG_N taken from bit WIDTH-1
//  DEPTH   2   buffer entries; fixed at 2 (skid), other values unsupported
// PORTS
//  CLK        in   1      single clock, rising edge
//  RST        in   1      synchronous reset, active-high
//  IN_VALID   in   1      upstream result present this cycle
//  IN_READY   out  1      stage can accept (buffer not full)
//  OP         in   2      00=AND 01=OR 10=XOR 11=ADD
//  RES_AND    in   WIDTH  AND unit output
//  RES_OR     in   WIDTH  OR unit output
//  RES_XOR    in   WIDTH  XOR unit output
//  RES_ADD    in   WIDTH  adder sum
//  ADD_COUT   in   1      adder carry-out
//  OUT_VALID  out  1      head entry valid
//  OUT_READY  in   1      consumer takes head entry
//  OUT_DATA   out  WIDTH  head result
//  OUT_Z      out  1      head result == 0
//  OUT_N      out  1      head result MSB
//  OUT_C      out  1      ADD_COUT if head OP==ADD, else 0
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (RST sampled on CLK rising edge).
//  - Reset: buffer empty; OUT_VALID=0, OUT_DATA=0, OUT_Z/N/C=0; IN_READY=0 in any cycle RST=1, 1 first cycle after.
//  - push = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY. All outputs are registered; none depends combinationally on OUT_READY.
//  - Mux/flags computed at push time; the entry stores {data,Z,N,C}. Flags never change while an entry is held.
//  - Latency: push in cycle t into empty buffer -> OUT_VALID=1 with that entry in cycle t+1.
//  - Count FSM: EMPTY(0) / ONE(1) / FULL(2); IN_READY = (state!=FULL), registered.
//     EMPTY: push->ONE.  ONE: push&!pop->FULL, pop&!push->EMPTY, push&pop->ONE (new entry becomes head next cycle).
//     FULL: pop->ONE (second entry becomes head); push impossible (IN_READY=0).
//  - Order is strict FIFO; no entry dropped or duplicated. IN_VALID with IN_READY=0 is ignored (upstream must hold).
//  - OUT_VALID & !OUT_READY: OUT_DATA/flags held stable until pop.
//  - Width rules: Z = ~|data; N = data[WIDTH-1]; C only for ADD; no sign extension, no overflow flag.
//  - RST mid-operation: all held entries discarded, outputs return to reset values next edge, regardless of handshakes.
//  - OP and RES_* are don't-care when IN_VALID=0; X on them must not propagate into stored state.
// STRUCTURE
//  - Shared package alu_pkg: OP_AND/OP_OR/OP_XOR/OP_ADD localparams, ALU_WIDTH=8, entry typedef {data,z,n,c}.
//  - One sub-module: alu_skid_buf (2-entry valid/ready skid buffer of alu_pkg entry type).
//  - Top holds only op mux + flag logic feeding alu_skid_buf; no other submodules.
// TESTING
//  1. Reset: RST=1 two cycles, IN_VALID=1 -> IN_READY=0, OUT_VALID=0, OUT_DATA=0x00; release -> IN_READY=1, nothing captured.
//  2. Single op: OP=00, RES_AND=0x80, OUT_READY=1 -> next cycle OUT_DATA=0x80, Z=0 N=1 C=0, OUT_VALID one cycle.
//  3. Flags: OP=11, RES_ADD=0x00, ADD_COUT=1 -> Z=1 N=0 C=1; same with OP=01, RES_OR=0x00 -> Z=1 C=0.
//  4. Backpressure: OUT_READY=0, push 0x11,0x22 -> IN_READY=0 after 2nd push, 3rd IN_VALID ignored; OUT_READY=1 -> 0x11 then 0x22.
//  5. Stream: OUT_READY=1, push 0x01..0x10 back-to-back -> IN_READY stays 1, outputs 0x01..0x10 in order, 1-cycle lag.
//  6. Mid-op reset: buffer FULL, assert RST one cycle -> OUT_VALID=0 next edge, held entries never appear after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// Op encodings, datapath width, buffered entry and fill-state types.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic                 z;
    logic                 n;
    logic                 c;
  } alu_entry_t;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } fill_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream handshake bundle of the ALU result stage.
// The master side drives operands and consumer ready; the slave side is the stage.
interface alu_result_stage_if;
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           op;
  logic [ALU_WIDTH-1:0] res_and;
  logic [ALU_WIDTH-1:0] res_or;
  logic [ALU_WIDTH-1:0] res_xor;
  logic [ALU_WIDTH-1:0] res_add;
  logic                 add_cout;
  logic                 out_valid;
  logic                 out_ready;
  logic [ALU_WIDTH-1:0] out_data;
  logic                 out_z;
  logic                 out_n;
  logic                 out_c;

  modport master (
    output in_valid, op, res_and, res_or, res_xor, res_add, add_cout, out_ready,
    input  in_ready, out_valid, out_data, out_z, out_n, out_c
  );

  modport slave (
    input  in_valid, op, res_and, res_or, res_xor, res_add, add_cout, out_ready,
    output in_ready, out_valid, out_data, out_z, out_n, out_c
  );

endinterface

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer for ALU result entries.
// Every output comes straight from a register; nothing depends combinationally on out_ready.
module alu_skid_buf
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  alu_entry_t in_entry,
  output logic       out_valid,
  input  logic       out_ready,
  output alu_entry_t out_entry
);

  fill_state_e state_q;
  alu_entry_t  head_q;
  alu_entry_t  tail_q;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        push;
  logic        pop;

  // Ready is forced low while reset is asserted so nothing is offered during reset.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = out_valid_q;
  assign out_entry = head_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            head_q      <= in_entry;
            out_valid_q <= 1'b1;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_q <= in_entry;
          end else if (push) begin
            tail_q     <= in_entry;
            in_ready_q <= 1'b0;
            state_q    <= StFull;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_q     <= tail_q;
            in_ready_q <= 1'b1;
            state_q    <= StOne;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage of the 8-bit ALU: op select, Z/N/C flag derivation,
// and a two-entry skid buffer toward the consumer.
module alu_result_stage
  import alu_pkg::*;
(
  input logic               clk,
  input logic               rst,
  alu_result_stage_if.slave bus
);

  logic [ALU_WIDTH-1:0] sel_data;
  alu_entry_t           in_entry;
  alu_entry_t           out_entry;

  always_comb begin
    sel_data = '0;
    unique case (bus.op)
      OP_AND:  sel_data = bus.res_and;
      OP_OR:   sel_data = bus.res_or;
      OP_XOR:  sel_data = bus.res_xor;
      OP_ADD:  sel_data = bus.res_add;
      default: sel_data = '0;
    endcase
  end

  always_comb begin
    in_entry      = '0;
    in_entry.data = sel_data;
    in_entry.z    = ~|sel_data;
    in_entry.n    = sel_data[ALU_WIDTH-1];
    in_entry.c    = (bus.op == OP_ADD) & bus.add_cout;
  end

  alu_skid_buf u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_entry  (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_entry (out_entry)
  );

  assign bus.out_data = out_entry.data;
  assign bus.out_z    = out_entry.z;
  assign bus.out_n    = out_entry.n;
  assign bus.out_c    = out_entry.c;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized scoreboard bench for alu_result_stage: expected entries are queued
// on accepted pushes and compared in FIFO order whenever the stage hands one out.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_result_stage_if bus ();

  alu_result_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [10:0] exp_q[$];
  bit          rand_done;

  // Expected {data, z, n, c} straight from the stage's arithmetic rules.
  function automatic logic [10:0] ref_entry(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] o, input logic [7:0] x,
                                            input logic [7:0] s, input logic cout);
    int unsigned d;
    case (op)
      2'd0:    d = a;
      2'd1:    d = o;
      2'd2:    d = x;
      default: d = s;
    endcase
    return {8'(d), d == 0, d >= 128, (op == 2'd3) && cout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation and hold it until accepted; returns cycles spent.
  task automatic drive(input logic [1:0] op, input logic [7:0] v, input logic cout,
                       output int waits);
    logic acc;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.res_and  = 8'($urandom);
    bus.res_or   = 8'($urandom);
    bus.res_xor  = 8'($urandom);
    bus.res_add  = 8'($urandom);
    bus.add_cout = (op == 2'd3) ? cout : 1'($urandom);
    case (op)
      2'd0:    bus.res_and = v;
      2'd1:    bus.res_or  = v;
      2'd2:    bus.res_xor = v;
      default: bus.res_add = v;
    endcase
    waits = 0;
    acc   = 1'b0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      waits++;
    end while (!acc && waits < 100);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL drive_timeout: got in_ready=0 for %0d cycles, want accept", waits);
    end
    bus.in_valid = 1'b0;
  endtask

  // Input monitor: record what every accepted push should produce.
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (bus.in_valid && bus.in_ready)
      exp_q.push_back(ref_entry(bus.op, bus.res_and, bus.res_or, bus.res_xor, bus.res_add,
                                bus.add_cout));
  end

  // Output monitor: compare each handed-out entry against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got 0x%0h, want no output", bus.out_data);
      end else begin
        check("out_entry", 32'({bus.out_data, bus.out_z, bus.out_n, bus.out_c}),
              32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int w;
    bus.in_valid  = 1'b1;
    bus.op        = 2'd0;
    bus.res_and   = 8'h5a;
    bus.res_or    = 8'h5a;
    bus.res_xor   = 8'h5a;
    bus.res_add   = 8'h5a;
    bus.add_cout  = 1'b0;
    bus.out_ready = 1'b0;
    rand_done     = 1'b0;

    // Reset held with in_valid asserted: nothing accepted, outputs at reset values.
    tick();
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'h00);
      tick();
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    tick();

    // Single AND op: one-cycle latency, valid for exactly one cycle.
    bus.out_ready = 1'b1;
    drive(2'd0, 8'h80, 1'b0, w);
    @(negedge clk);
    check("single_valid_hi", 32'(bus.out_valid), 32'd1);
    check("single_entry", 32'({bus.out_data, bus.out_z, bus.out_n, bus.out_c}),
          32'({8'h80, 1'b0, 1'b1, 1'b0}));
    tick();
    @(negedge clk);
    check("single_valid_lo", 32'(bus.out_valid), 32'd0);
    tick();

    // Zero results: carry only reported for ADD.
    drive(2'd3, 8'h00, 1'b1, w);
    drive(2'd1, 8'h00, 1'b1, w);
    repeat (3) tick();

    // Backpressure: two entries fill the buffer, a third offer is ignored.
    bus.out_ready = 1'b0;
    drive(2'($urandom), 8'h11, 1'($urandom), w);
    drive(2'($urandom), 8'h22, 1'($urandom), w);
    bus.in_valid = 1'b1;
    bus.res_and  = 8'h33;
    bus.res_or   = 8'h33;
    bus.res_xor  = 8'h33;
    bus.res_add  = 8'h33;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_head_held", 32'(bus.out_data), 32'h11);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("bp_drained_q", 32'(exp_q.size()), 32'd0);
    check("bp_drained_valid", 32'(bus.out_valid), 32'd0);
    tick();

    // Back-to-back stream with a consumer that never stalls.
    for (int i = 1; i <= 16; i++) begin
      drive(2'($urandom), 8'(i), 1'($urandom), w);
      check("stream_no_stall", 32'(w), 32'd1);
    end
    repeat (3) tick();

    // Reset while full: held entries must be discarded.
    bus.out_ready = 1'b0;
    drive(2'($urandom), 8'($urandom), 1'($urandom), w);
    drive(2'($urandom), 8'($urandom), 1'($urandom), w);
    @(negedge clk);
    check("midrst_full", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("midrst_no_ghost", 32'(bus.out_valid), 32'd0);
    tick();

    // Random traffic with random consumer stalls.
    fork
      begin
        while (!rand_done) begin
          bus.out_ready = 1'($urandom);
          tick();
        end
      end
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          drive(2'($urandom), 8'($urandom), 1'($urandom), w);
        end
        rand_done = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    tick();
    @(negedge clk);
    check("final_drain_q", 32'(exp_q.size()), 32'd0);
    check("final_out_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
